gtxe2_chnl_cpll_lockdet: RTL
============================

// Module: gtxe2_chnl_cpll_lockdet
// PURPOSE
//  CPLL lock detector for the GTXE2 channel model.
//  Runs on the lock-detect clock (CPLLLOCKDETCLK) and counts edges of a divided reference clock and a divided CPLL feedback clock over fixed windows.
//  Produces CPLLLOCK, CPLLREFCLKLOST and CPLLFBCLKLOST.
//  Sits directly downstream of the channel clocking stage: ref_div/fb_div are clock_divider outputs fed from the CPLL input-mux output and the CPLL output.
// PARAMETERS
//  WINDOW       256  lockdet clk cycles per measurement window (>=4)
//  CNT_W        16   edge counter width; counters saturate at 2^CNT_W-1
//  FB_MULT      1    expected fb_div edges per ref_div edge (1..255)
//  TOL          2    allowed |fb_cnt - ref_cnt*FB_MULT| for a good window
//  LOCK_WINDOWS 4    consecutive good windows required to assert lock (>=1)
// PORTS
//  clk          in  1      lock-detect clock (CPLLLOCKDETCLK)
//  rst_n        in  1      asynchronous active-low reset
//  lock_en      in  1      CPLLLOCKEN; 0 forces OFF
//  pd           in  1      CPLLPD; 1 forces OFF
//  ref_div      in  1      divided reference clock; asynchronous, slower than clk/2
//  fb_div       in  1      divided feedback clock; asynchronous, slower than clk/2
//  lock         out 1      CPLLLOCK
//  refclk_lost  out 1      CPLLREFCLKLOST
//  fbclk_lost   out 1      CPLLFBCLKLOST
//  window_done  out 1      1-cycle pulse, registered, after each evaluated window
// BEHAVIOUR
//  Reset: all outputs 0; state OFF; all counters 0. Reset is asynchronous and takes effect mid-window.
//  Input path: ref_div and fb_div each pass through a 2FF synchronizer plus one edge flop.
//   - Rising-edge pulse appears 3 clk after the input edge.
//  Counting:
//   - win_cnt runs 0..WINDOW-1 and wraps.
//   - ref_cnt/fb_cnt increment on their edge pulses, saturating.
//   - Cycle with win_cnt==WINDOW-1 is the window end. Evaluation uses counts including that cycle's edges.
//   - All three counters restart at 0 on the next cycle.
//  Evaluation at window end:
//   - Arithmetic is done in CNT_W+8 bits, unsigned.
//   - good = ref_cnt!=0 && fb_cnt!=0 && |fb_cnt - ref_cnt*FB_MULT| <= TOL.
//   - refclk_lost <= (ref_cnt==0).
//   - fbclk_lost <= (ref_cnt!=0 && fb_cnt==0).
//   - Both flags update only at window end. Neither flag is sticky.
//  FSM:
//   - OFF: entered from any state whenever pd==1 or lock_en==0, effective on the next clk. Counters held at 0; lock, refclk_lost, fbclk_lost and window_done forced to 0. Leaves to ACQUIRE when pd==0 && lock_en==1, with a fresh window starting at win_cnt=0.
//   - ACQUIRE: good_cnt increments on a good window and clears on a bad one. The window that makes good_cnt reach LOCK_WINDOWS moves the FSM to LOCKED.
//   - LOCKED: lock=1. One bad window returns the FSM to ACQUIRE with good_cnt=0 and lock=0.
//  Timing: lock and the lost flags change one clk after the window-end cycle, together with window_done.
//  Simultaneous events: a pd/lock_en drop in the window-end cycle takes priority. The evaluation is discarded and the FSM goes to OFF.
// STRUCTURE
//  Shared header gtxe2_chnl_lockdet_defs.vh holds:
//   - FSM state encodings (OFF=2'd0, ACQUIRE=2'd1, LOCKED=2'd2)
//   - the CNT_W+8 compare-width localparam
//  Sub-module gtxe2_chnl_edge_sync: 2FF synchronizer plus rising-edge pulse. Instantiated twice (ref_div, fb_div).
//  Top level holds the window counter, edge counters, evaluator and FSM.
// TESTING
//  1. clk 10ns. ref_div and fb_div both period 80ns, aligned. Defaults.
//     -> 32 edges per window each.
//     -> lock=1 one clk after the 4th window end (~1024+1 clk), stays 1.
//  2. From the locked state of case 1, stop fb_div.
//     -> At the first window end with fb_cnt==0: fbclk_lost=1, lock=0, refclk_lost=0.
//     -> Restart fb_div: fbclk_lost clears at the next window end; lock returns 4 windows later.
//  3. Stop ref_div (fb running).
//     -> refclk_lost=1, fbclk_lost=0, lock=0 at the next window end.
//  4. ref period 80ns, fb period 70ns.
//     -> 32 vs ~36 edges, diff 4 > TOL.
//     -> lock stays 0 indefinitely; no lost flags.
//  5. Locked, then lock_en=0 for 1 clk.
//     -> lock=0 and window_done=0 the next clk.
//     -> Re-acquire requires 4 full windows from re-enable.
//     -> Same check with pd=1 asserted in the window-end cycle.
//  6. rst_n low mid-window while locked.
//     -> lock, refclk_lost, fbclk_lost drop immediately, with no clk edge.
//     -> After release, the first window starts at win_cnt=0.

Source files
------------

// File: rtl/gtxe2_chnl_cpll_lockdet_pkg.sv
// Shared types and width helpers for the GTXE2 CPLL lock detector.
package gtxe2_chnl_cpll_lockdet_pkg;

    // Lock detector FSM states
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lockdet_state_e;

    // Headroom above the edge counter width for the ref*FB_MULT product
    localparam int unsigned CMP_PAD_W = 8;

    // Width used for the window evaluation arithmetic
    function automatic int unsigned cmp_width(input int unsigned cnt_w);
        return cnt_w + CMP_PAD_W;
    endfunction

endpackage

// File: rtl/gtxe2_chnl_cpll_lockdet_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for a slow async clock.
module gtxe2_chnl_cpll_lockdet_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    // Synchronize, delay once, and register the rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL lock detector: compares divided ref/fb edge counts over fixed windows.
module gtxe2_chnl_cpll_lockdet
    import gtxe2_chnl_cpll_lockdet_pkg::*;
#(
    parameter int unsigned WINDOW       = 256,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FB_MULT      = 1,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_en,
    input  logic pd,
    input  logic ref_div,
    input  logic fb_div,
    output logic lock,
    output logic refclk_lost,
    output logic fbclk_lost,
    output logic window_done
);

    localparam int unsigned WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned CMP_W  = cmp_width(CNT_W);
    localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    lockdet_state_e      r_state;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [CNT_W-1:0]    r_ref_cnt;
    logic [CNT_W-1:0]    r_fb_cnt;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic                r_lock;
    logic                r_refclk_lost;
    logic                r_fbclk_lost;
    logic                r_window_done;

    logic                w_ref_edge;
    logic                w_fb_edge;
    logic                w_run_en;
    logic                w_win_end;
    logic [CNT_W-1:0]    w_ref_tot;
    logic [CNT_W-1:0]    w_fb_tot;
    logic [CMP_W-1:0]    w_ref_ext;
    logic [CMP_W-1:0]    w_fb_ext;
    logic [CMP_W-1:0]    w_exp;
    logic [CMP_W-1:0]    w_diff;
    logic                w_ref_zero;
    logic                w_fb_zero;
    logic                w_good;
    logic [GOOD_W-1:0]   w_good_next;
    logic                w_good_full;

    gtxe2_chnl_cpll_lockdet_edge_sync u_ref_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ref_div),
        .o_rise  (w_ref_edge)
    );

    gtxe2_chnl_cpll_lockdet_edge_sync u_fb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (fb_div),
        .o_rise  (w_fb_edge)
    );

    assign w_run_en  = lock_en & ~pd;
    assign w_win_end = (r_win_cnt == WIN_LAST);

    // Saturating counts including the current cycle's edge pulses
    assign w_ref_tot = (w_ref_edge && (r_ref_cnt != CNT_MAX)) ? r_ref_cnt + CNT_W'(1) : r_ref_cnt;
    assign w_fb_tot  = (w_fb_edge  && (r_fb_cnt  != CNT_MAX)) ? r_fb_cnt  + CNT_W'(1) : r_fb_cnt;

    // Window evaluation in widened unsigned arithmetic
    assign w_ref_ext  = CMP_W'(w_ref_tot);
    assign w_fb_ext   = CMP_W'(w_fb_tot);
    assign w_exp      = w_ref_ext * CMP_W'(FB_MULT);
    assign w_diff     = (w_fb_ext >= w_exp) ? (w_fb_ext - w_exp) : (w_exp - w_fb_ext);
    assign w_ref_zero = (w_ref_tot == '0);
    assign w_fb_zero  = (w_fb_tot == '0);
    assign w_good     = !w_ref_zero && !w_fb_zero && (w_diff <= CMP_W'(TOL));

    assign w_good_next = r_good_cnt + GOOD_W'(1);
    assign w_good_full = (w_good_next == GOOD_W'(LOCK_WINDOWS));

    // Window counters, evaluation and lock FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_win_cnt     <= '0;
            r_ref_cnt     <= '0;
            r_fb_cnt      <= '0;
            r_good_cnt    <= '0;
            r_lock        <= 1'b0;
            r_refclk_lost <= 1'b0;
            r_fbclk_lost  <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            if (!w_run_en) begin
                // Disable wins over everything, including a window end this cycle
                r_state       <= ST_OFF;
                r_win_cnt     <= '0;
                r_ref_cnt     <= '0;
                r_fb_cnt      <= '0;
                r_good_cnt    <= '0;
                r_lock        <= 1'b0;
                r_refclk_lost <= 1'b0;
                r_fbclk_lost  <= 1'b0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state    <= ST_ACQUIRE;
                        r_win_cnt  <= '0;
                        r_ref_cnt  <= '0;
                        r_fb_cnt   <= '0;
                        r_good_cnt <= '0;
                    end
                    ST_ACQUIRE, ST_LOCKED: begin
                        if (w_win_end) begin
                            r_win_cnt     <= '0;
                            r_ref_cnt     <= '0;
                            r_fb_cnt      <= '0;
                            r_window_done <= 1'b1;
                            r_refclk_lost <= w_ref_zero;
                            r_fbclk_lost  <= !w_ref_zero && w_fb_zero;
                            if (r_state == ST_ACQUIRE) begin
                                if (!w_good) begin
                                    r_good_cnt <= '0;
                                end else if (w_good_full) begin
                                    r_state    <= ST_LOCKED;
                                    r_lock     <= 1'b1;
                                    r_good_cnt <= '0;
                                end else begin
                                    r_good_cnt <= w_good_next;
                                end
                            end else if (!w_good) begin
                                r_state    <= ST_ACQUIRE;
                                r_lock     <= 1'b0;
                                r_good_cnt <= '0;
                            end
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                            r_ref_cnt <= w_ref_tot;
                            r_fb_cnt  <= w_fb_tot;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lock        = r_lock;
    assign refclk_lost = r_refclk_lost;
    assign fbclk_lost  = r_fbclk_lost;
    assign window_done = r_window_done;

endmodule
